// File: rtl/oam_dma_engine.sv
// oam_dma_engine: copies LENGTH bytes from a CPU-selected page into OAM, arbitrating the CPU off the system bus while it runs.
// CPU reads of the page register and of blocked addresses are answered locally; HRAM stays CPU-private throughout.
module oam_dma_engine #(
  parameter int          LENGTH      = 160,
  parameter int          BYTE_CYCLES = 4,
  parameter int          START_DELAY = 4,
  parameter logic [15:0] REG_ADDR    = 16'hFF46,
  parameter logic [15:0] HRAM_LO     = 16'hFF80,
  parameter logic [15:0] HRAM_HI     = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_enable,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic [15:0] bus_addr,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [7:0]  bus_data_out,
  input  logic [7:0]  bus_data_in,
  output logic        hram_enable,
  output logic [7:0]  oam_addr,
  output logic        oam_write,
  output logic [7:0]  oam_data,
  output logic        dma_active
);
  localparam int IW = LENGTH > 1 ? $clog2(LENGTH) : 1;
  localparam int PW = $clog2(BYTE_CYCLES);
  localparam int DW = $clog2(START_DELAY + 1);
  localparam logic [IW-1:0] I_LAST = IW'(LENGTH - 1);
  localparam logic [PW-1:0] P_LAST = PW'(BYTE_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(START_DELAY - 1);
  localparam logic [1:0] SEL_BUS = 2'd0, SEL_REG = 2'd1, SEL_BLK = 2'd2;

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  state_t          r_state;
  logic [7:0]      r_src;
  logic [IW-1:0]   r_idx;
  logic [PW-1:0]   r_ph;
  logic [DW-1:0]   r_dly;
  logic [1:0]      r_sel;

  logic       w_is_reg, w_is_hram, w_xfer, w_reg_wr, w_pass, w_dma_rd;
  logic [7:0] w_page;

  assign w_is_reg  = cpu_addr == REG_ADDR;
  assign w_is_hram = cpu_addr >= HRAM_LO && cpu_addr <= HRAM_HI;
  assign w_xfer    = r_state == XFER;
  assign w_reg_wr  = cpu_enable & cpu_write & w_is_reg;
  assign w_pass    = ~w_xfer & ~w_is_reg & ~w_is_hram;
  assign w_dma_rd  = w_xfer & (r_ph == '0);
  // Pages E0..FF alias the echo region back onto C0..DF.
  assign w_page    = r_src >= 8'hE0 ? r_src - 8'h20 : r_src;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_src   <= 8'hFF;
      r_idx   <= '0;
      r_ph    <= '0;
      r_dly   <= '0;
      r_sel   <= SEL_BUS;
    end else begin
      r_sel <= w_is_reg ? SEL_REG : (w_xfer && !w_is_hram) ? SEL_BLK : SEL_BUS;
      if (w_reg_wr) begin
        r_src   <= cpu_data_out;
        r_state <= DELAY;
        r_idx   <= '0;
        r_ph    <= '0;
        r_dly   <= '0;
      end else if (r_state == DELAY) begin
        if (r_dly == D_LAST) r_state <= XFER;
        r_dly <= r_dly + 1'b1;
      end else if (w_xfer) begin
        r_ph <= r_ph == P_LAST ? '0 : r_ph + 1'b1;
        if (r_ph == P_LAST) begin
          if (r_idx == I_LAST) r_state <= IDLE;
          else r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus_addr     = w_dma_rd ? {w_page, 8'h00} + 16'(r_idx) : w_pass ? cpu_addr : 16'h0000;
    bus_enable   = w_dma_rd | (w_pass & cpu_enable);
    bus_write    = w_pass & cpu_write;
    bus_data_out = w_pass ? cpu_data_out : 8'h00;
    hram_enable  = w_is_hram & cpu_enable;
    oam_write    = w_xfer & (r_ph == PW'(1));
    oam_addr     = oam_write ? 8'(r_idx) : 8'h00;
    oam_data     = oam_write ? bus_data_in : 8'h00;
    dma_active   = w_xfer;
    cpu_data_in  = r_sel == SEL_REG ? r_src : r_sel == SEL_BLK ? 8'hFF : bus_data_in;
  end
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: scoreboard bench for the OAM DMA engine with a 64K bus memory model and OAM capture.
module tb_oam_dma_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [15:0] cpu_addr, bus_addr;
  logic        cpu_enable, cpu_write, bus_enable, bus_write, hram_enable, oam_write, dma_active;
  logic [7:0]  cpu_data_out, cpu_data_in, bus_data_out, bus_data_in, oam_addr, oam_data;

  logic [15:0] c1_addr, b1_addr;
  logic        c1_en, c1_wr, b1_en, b1_wr, h1, o1_wr, o1_active;
  logic [7:0]  c1_do, c1_din, b1_do, b1_din, o1_addr, o1_data;

  typedef struct {logic [15:0] src; logic [7:0] idx; logic [7:0] dat;} exp_t;
  exp_t q[$];

  int total = 0, bad = 0, n_oam = 0, n1 = 0;
  logic [7:0]  mem  [0:65535];
  logic [7:0]  oam  [0:255];
  logic [7:0]  oam1 [0:255];
  logic [7:0]  snap [0:255];
  logic        s_hram, s_ben, s_bwr;
  logic [15:0] s_baddr;

  oam_dma_engine u0 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_enable(cpu_enable),
    .cpu_write(cpu_write), .cpu_data_out(cpu_data_out), .cpu_data_in(cpu_data_in),
    .bus_addr(bus_addr), .bus_enable(bus_enable), .bus_write(bus_write),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .hram_enable(hram_enable),
    .oam_addr(oam_addr), .oam_write(oam_write), .oam_data(oam_data), .dma_active(dma_active)
  );

  oam_dma_engine #(.LENGTH(16), .BYTE_CYCLES(2)) u1 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(c1_addr), .cpu_enable(c1_en),
    .cpu_write(c1_wr), .cpu_data_out(c1_do), .cpu_data_in(c1_din),
    .bus_addr(b1_addr), .bus_enable(b1_en), .bus_write(b1_wr),
    .bus_data_out(b1_do), .bus_data_in(b1_din), .hram_enable(h1),
    .oam_addr(o1_addr), .oam_write(o1_wr), .oam_data(o1_data), .dma_active(o1_active)
  );

  function automatic logic [7:0] pat(input int a);
    return (a[15:8] == 8'hC1) ? a[7:0] : 8'(a * 7 + (a >> 8) * 13 + 3);
  endfunction

  // Synchronous-read memory, reloaded with the pattern while reset is held.
  always @(posedge clk) begin
    if (!reset_n) for (int a = 0; a < 65536; a++) mem[a] <= pat(a);
    else if (bus_enable && bus_write) mem[bus_addr] <= bus_data_out;
    if (bus_enable && !bus_write) bus_data_in <= mem[bus_addr];
    if (b1_en && !b1_wr) b1_din <= mem[b1_addr];
  end

  always @(posedge clk) begin
    if (oam_write) oam[oam_addr] <= oam_data;
    if (o1_wr) begin
      oam1[o1_addr] <= o1_data;
      n1 <= n1 + 1;
    end
  end

  task automatic sb_monitor();
    forever begin
      @(negedge clk);
      if (dma_active && bus_enable && !bus_write) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL dma_src got=%h exp=none", bus_addr);
        end else if (bus_addr !== q[0].src) begin
          bad++; $display("FAIL dma_src got=%h exp=%h", bus_addr, q[0].src);
        end
      end
      if (oam_write) begin
        total++; n_oam++;
        if (q.size() == 0) begin
          bad++; $display("FAIL oam_wr unexpected got addr=%h data=%h", oam_addr, oam_data);
        end else begin
          if ({oam_addr, oam_data} !== {q[0].idx, q[0].dat}) begin
            bad++;
            $display("FAIL oam_wr got addr=%h data=%h exp addr=%h data=%h", oam_addr, oam_data, q[0].idx, q[0].dat);
          end
          void'(q.pop_front());
        end
      end
    end
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic w, input logic [7:0] d, output logic [7:0] r);
    cpu_addr = a; cpu_write = w; cpu_data_out = d; cpu_enable = 1'b1;
    @(negedge clk);
    s_hram = hram_enable; s_ben = bus_enable; s_baddr = bus_addr; s_bwr = bus_write;
    @(posedge clk); #1;
    cpu_enable = 1'b0; cpu_write = 1'b0;
    r = cpu_data_in;
  endtask

  task automatic start(input logic [7:0] p);
    logic [7:0] e, r;
    logic [15:0] s;
    e = p >= 8'hE0 ? p - 8'h20 : p;
    for (int i = 0; i < 160; i++) begin
      s = {e, 8'h00} + 16'(i);
      q.push_back('{src: s, idx: 8'(i), dat: mem[s]});
    end
    cpu_access(16'hFF46, 1'b1, p, r);
  endtask

  task automatic wait_active(output int d);
    d = 0;
    while (!dma_active && d < 100) begin @(posedge clk); #1; d++; end
  endtask

  task automatic wait_idle(output int a);
    a = 0;
    while (dma_active && a < 5000) begin @(posedge clk); #1; a++; end
  endtask

  task automatic test_reset();
    logic [7:0] r;
    cpu_addr = 16'hC000; cpu_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b exp=0", dma_active); end
    total++; if (oam_write !== 1'b0) begin bad++; $display("FAIL rst_oam_wr got=%b exp=0", oam_write); end
    total++; if ({bus_enable, bus_addr} !== {1'b1, 16'hC000}) begin bad++; $display("FAIL rst_pass got=%b/%h exp=1/c000", bus_enable, bus_addr); end
    total++; if (hram_enable !== 1'b0) begin bad++; $display("FAIL rst_hram got=%b exp=0", hram_enable); end
    cpu_enable = 1'b0; reset_n = 1'b1;
    @(posedge clk); #1;
    cpu_access(16'hFF46, 1'b0, 8'h00, r);
    total++; if (r !== 8'hFF) begin bad++; $display("FAIL rst_page got=%h exp=ff", r); end
    total++; if (s_ben !== 1'b0) begin bad++; $display("FAIL reg_not_fwd got=%b exp=0", s_ben); end
  endtask

  task automatic test_basic();
    int d, a;
    start(8'hC1);
    wait_active(d);
    total++; if (d !== 4) begin bad++; $display("FAIL basic_delay got=%0d exp=4", d); end
    wait_idle(a);
    total++; if (a !== 640) begin bad++; $display("FAIL basic_active got=%0d exp=640", a); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL basic_left got=%0d exp=0", q.size()); end
    for (int i = 0; i < 160; i++) begin
      total++; if (oam[i] !== 8'(i)) begin bad++; $display("FAIL basic_oam[%0d] got=%h exp=%h", i, oam[i], 8'(i)); end
    end
  endtask

  task automatic test_passthrough();
    logic [7:0] r;
    cpu_access(16'hC105, 1'b0, 8'h00, r);
    total++; if (r !== 8'h05) begin bad++; $display("FAIL pass_rd got=%h exp=05", r); end
    total++; if ({s_ben, s_baddr} !== {1'b1, 16'hC105}) begin bad++; $display("FAIL pass_bus got=%b/%h exp=1/c105", s_ben, s_baddr); end
    cpu_access(16'hD000, 1'b1, 8'h77, r);
    total++; if (mem[16'hD000] !== 8'h77) begin bad++; $display("FAIL pass_wr got=%h exp=77", mem[16'hD000]); end
    cpu_access(16'hFF80, 1'b0, 8'h00, r);
    total++; if ({s_hram, s_ben} !== 2'b10) begin bad++; $display("FAIL idle_hram got=%b%b exp=10", s_hram, s_ben); end
  endtask

  task automatic test_block();
    logic [7:0] r;
    int d, a;
    start(8'hC1);
    wait_active(d);
    cpu_access(16'hC000, 1'b0, 8'h00, r);
    total++; if (r !== 8'hFF) begin bad++; $display("FAIL blk_rd got=%h exp=ff", r); end
    total++; if (s_ben && s_baddr == 16'hC000) begin bad++; $display("FAIL blk_bus got=%b/%h exp=no c000", s_ben, s_baddr); end
    cpu_access(16'hC000, 1'b1, 8'hAB, r);
    total++; if (s_bwr !== 1'b0) begin bad++; $display("FAIL blk_bwr got=%b exp=0", s_bwr); end
    cpu_access(16'hFF90, 1'b1, 8'h12, r);
    total++; if (s_hram !== 1'b1) begin bad++; $display("FAIL xfer_hram got=%b exp=1", s_hram); end
    total++; if (dma_active !== 1'b1) begin bad++; $display("FAIL blk_active got=%b exp=1", dma_active); end
    wait_idle(a);
    total++; if (mem[16'hC000] !== pat('hC000)) begin bad++; $display("FAIL blk_drop got=%h exp=%h", mem[16'hC000], pat('hC000)); end
    total++; if (mem[16'hFF90] !== pat('hFF90)) begin bad++; $display("FAIL hram_fwd got=%h exp=%h", mem[16'hFF90], pat('hFF90)); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL blk_left got=%0d exp=0", q.size()); end
  endtask

  task automatic test_restart();
    int d, a, base, g;
    start(8'hC1);
    wait_active(d);
    base = n_oam; g = 0;
    while (n_oam - base < 50 && g < 5000) begin @(posedge clk); #1; g++; end
    total++; if (n_oam - base !== 50) begin bad++; $display("FAIL rs_reach got=%0d exp=50", n_oam - base); end
    q.delete();
    start(8'hC2);
    wait_active(d);
    total++; if (d !== 4) begin bad++; $display("FAIL rs_delay got=%0d exp=4", d); end
    wait_idle(a);
    total++; if (a !== 640) begin bad++; $display("FAIL rs_active got=%0d exp=640", a); end
    for (int i = 0; i < 160; i++) begin
      total++; if (oam[i] !== mem[16'hC200 + 16'(i)]) begin bad++; $display("FAIL rs_oam[%0d] got=%h exp=%h", i, oam[i], mem[16'hC200 + 16'(i)]); end
    end
  endtask

  task automatic test_high_page();
    logic [7:0] r;
    int d, a;
    start(8'hFE);
    wait_active(d);
    wait_idle(a);
    total++; if (a !== 640) begin bad++; $display("FAIL hp_active got=%0d exp=640", a); end
    total++; if (q.size() !== 0) begin bad++; $display("FAIL hp_left got=%0d exp=0", q.size()); end
    cpu_access(16'hFF46, 1'b0, 8'h00, r);
    total++; if (r !== 8'hFE) begin bad++; $display("FAIL hp_page got=%h exp=fe", r); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] r;
    int d, base, g;
    start(8'hC4);
    wait_active(d);
    for (int i = 0; i < 256; i++) snap[i] = oam[i];
    base = n_oam; g = 0;
    while (n_oam - base < 80 && g < 5000) begin @(posedge clk); #1; g++; end
    reset_n = 1'b0;
    #1;
    total++; if (dma_active !== 1'b0) begin bad++; $display("FAIL ab_active got=%b exp=0", dma_active); end
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 160; i++) begin
      r = i < 80 ? mem[16'hC400 + 16'(i)] : snap[i];
      total++; if (oam[i] !== r) begin bad++; $display("FAIL ab_oam[%0d] got=%h exp=%h", i, oam[i], r); end
    end
    cpu_access(16'hFF46, 1'b0, 8'h00, r);
    total++; if (r !== 8'hFF) begin bad++; $display("FAIL ab_page got=%h exp=ff", r); end
  endtask

  task automatic test_small();
    int d, a;
    c1_addr = 16'hFF46; c1_wr = 1'b1; c1_do = 8'hC3; c1_en = 1'b1;
    @(posedge clk); #1;
    c1_en = 1'b0; c1_wr = 1'b0;
    d = 0;
    while (!o1_active && d < 100) begin @(posedge clk); #1; d++; end
    total++; if (d !== 4) begin bad++; $display("FAIL sm_delay got=%0d exp=4", d); end
    a = 0;
    while (o1_active && a < 1000) begin @(posedge clk); #1; a++; end
    total++; if (a !== 32) begin bad++; $display("FAIL sm_active got=%0d exp=32", a); end
    total++; if (n1 !== 16) begin bad++; $display("FAIL sm_count got=%0d exp=16", n1); end
    for (int i = 0; i < 16; i++) begin
      total++; if (oam1[i] !== mem[16'hC300 + 16'(i)]) begin bad++; $display("FAIL sm_oam[%0d] got=%h exp=%h", i, oam1[i], mem[16'hC300 + 16'(i)]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_addr = '0; cpu_enable = 1'b0; cpu_write = 1'b0; cpu_data_out = '0;
    c1_addr = '0; c1_en = 1'b0; c1_wr = 1'b0; c1_do = '0;
    fork sb_monitor(); join_none
    test_reset();
    test_basic();
    test_passthrough();
    test_block();
    test_restart();
    test_high_page();
    test_reset_abort();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
